// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mem_pkg
//  Description : Shared encodings for the RV32I MEM-stage data-memory path.
//                Holds the store-size encoding, load funct3 codes, the
//                ResultSrc value that marks a load, the dmem_ctrl state
//                encoding and a helper that maps a load funct3 to an
//                access size.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    // Store size as carried by MemWriteM
    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } store_size_e;

    // Load funct3 codes
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // ResultSrcM value selecting the memory read result
    localparam logic [1:0] RESULT_MEM = 2'b01;

    // dmem_ctrl state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // Access size of a load. Undefined funct3 codes are treated as byte
    // accesses so they never raise a misalignment; their data returns 0.
    function automatic logic [1:0] load_size(input logic [2:0] f3);
        logic [1:0] v_size;
        case (f3)
            c_f3_lh, c_f3_lhu: v_size = SZ_HALF;
            c_f3_lw:           v_size = SZ_WORD;
            default:           v_size = SZ_BYTE;
        endcase
        return v_size;
    endfunction

endpackage : rv_mem_pkg
`default_nettype wire

// File: rtl/dmem_align.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_align
//  Description : Combinational byte-lane logic for the data bus.
//                Store path: byte enables and lane-replicated write data
//                from the access size and address offset.
//                Load path: selects the byte/half lane of the bus read data
//                using the offset and funct3 captured at request time, then
//                sign- or zero-extends.
//  Ports       : st_size/st_off/st_data -> st_be/st_wdata (store lanes)
//                ld_funct3/ld_off/ld_rdata -> ld_data   (load extend)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lanes
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            SZ_WORD: begin
                st_be    = 4'b1111;
            end
            default: begin
                st_be    = 4'b0000;
            end
        endcase
    end

    // Load lane select and extension
    always_comb begin
        w_byte  = ld_rdata[{ld_off, 3'b000} +: 8];
        w_half  = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        ld_data = 32'h0000_0000;
        case (ld_funct3)
            c_f3_lb:  ld_data = {{24{w_byte[7]}}, w_byte};
            c_f3_lh:  ld_data = {{16{w_half[15]}}, w_half};
            c_f3_lw:  ld_data = ld_rdata;
            c_f3_lbu: ld_data = {24'h000000, w_byte};
            c_f3_lhu: ld_data = {16'h0000, w_half};
            default:  ld_data = 32'h0000_0000;
        endcase
    end

endmodule : dmem_align
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl
//  Description : MEM-stage data-memory access controller. Runs the load or
//                store held in EX/MEM as a req/gnt/rvalid bus transaction,
//                freezing the pipeline (StallMem) while it is in flight.
//                Misaligned accesses are suppressed with a MisalignM pulse;
//                accesses that exceed TIMEOUT cycles end with BusErrM.
//  Ports       : clk, rst                      clock, sync active-high reset
//                MemWriteM, ResultSrcM,
//                LoadSizeM, ALUResultM,
//                WriteDataM                    access from EX/MEM
//                StallMem, ReadDataM,
//                MisalignM, BusErrM            pipeline side results
//                dbus_req/we/addr/be/wdata     bus request (registered)
//                dbus_gnt, dbus_rvalid,
//                dbus_rdata                    bus handshake / read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  LoadSizeM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        StallMem,
    output logic [31:0] ReadDataM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata
);

    // Counter is at least 8 bits, wider only if TIMEOUT needs it
    localparam int c_cnt_w = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [2:0]         r_f3;
    logic [1:0]         r_off;
    logic               r_stall;
    logic [31:0]        r_rdata;
    logic               r_buserr;

    logic               w_is_store;
    logic               w_is_load;
    logic               w_access;
    logic [1:0]         w_size;
    logic               w_misalign;
    logic               w_go;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic               w_timeout;
    logic [3:0]         w_st_be;
    logic [31:0]        w_st_wdata;
    logic [31:0]        w_ld_data;

    // Access decode; a store wins when both store and load are flagged
    always_comb begin
        w_is_store = (MemWriteM != SZ_NONE);
        w_is_load  = (ResultSrcM == RESULT_MEM);
        w_access   = w_is_store | w_is_load;
        w_size     = w_is_store ? MemWriteM : load_size(LoadSizeM);
        w_misalign = w_access &&
                     (((w_size == SZ_HALF) && ALUResultM[0]) ||
                      ((w_size == SZ_WORD) && (ALUResultM[1:0] != 2'b00)));
        w_go       = (r_state == c_st_idle) && w_access && !w_misalign;
        w_cnt_next = r_cnt + 1'b1;
        // Expires on the cycle whose increment would reach TIMEOUT
        w_timeout  = (w_cnt_next == c_timeout);
    end

    dmem_align u_align (
        .st_size   (w_size),
        .st_off    (ALUResultM[1:0]),
        .st_data   (WriteDataM),
        .st_be     (w_st_be),
        .st_wdata  (w_st_wdata),
        .ld_funct3 (r_f3),
        .ld_off    (r_off),
        .ld_rdata  (dbus_rdata),
        .ld_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_f3     <= 3'b000;
            r_off    <= 2'b00;
            r_stall  <= 1'b0;
            r_rdata  <= 32'h0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_buserr <= 1'b0;
                    if (w_go) begin
                        r_state <= c_st_req;
                        r_cnt   <= '0;
                        r_req   <= 1'b1;
                        r_stall <= 1'b1;
                        r_we    <= w_is_store;
                        r_addr  <= {ALUResultM[31:2], 2'b00};
                        r_be    <= w_st_be;
                        r_wdata <= w_is_store ? w_st_wdata : 32'h0;
                        r_f3    <= LoadSizeM;
                        r_off   <= ALUResultM[1:0];
                    end
                end
                c_st_req: begin
                    // A grant in the expiry cycle still counts as a grant
                    if (dbus_gnt) begin
                        r_state <= c_st_wait;
                        r_req   <= 1'b0;
                        r_cnt   <= w_cnt_next;
                    end else if (w_timeout) begin
                        r_state  <= c_st_done;
                        r_req    <= 1'b0;
                        r_stall  <= 1'b0;
                        r_rdata  <= 32'h0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                c_st_wait: begin
                    if (dbus_rvalid) begin
                        r_state <= c_st_done;
                        r_stall <= 1'b0;
                        r_rdata <= r_we ? 32'h0 : w_ld_data;
                    end else if (w_timeout) begin
                        r_state  <= c_st_done;
                        r_stall  <= 1'b0;
                        r_rdata  <= 32'h0;
                        r_buserr <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_next;
                    end
                end
                c_st_done: begin
                    // Pipeline advances on this edge; the next MEM
                    // instruction is decoded in IDLE on the following cycle
                    r_state  <= c_st_idle;
                    r_buserr <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Combinational outputs are held low while reset is asserted
    assign StallMem   = !rst && (w_go || r_stall);
    assign MisalignM  = !rst && (r_state == c_st_idle) && w_misalign;
    assign ReadDataM  = r_rdata;
    assign BusErrM    = r_buserr;
    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_be    = r_be;
    assign dbus_wdata = r_wdata;

endmodule : dmem_ctrl
`default_nettype wire
